// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between the CPU core (port 0) and the
// host loader/debug port (port 1). Each transaction takes an ACCESS cycle, where
// the RAM is driven from registers and acts on the negedge, then an ACK cycle,
// where the read data is returned with a one-cycle ack pulse.
// Optional feature: define RAM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise port 0 has fixed priority.
module ram_arbiter #(
   parameter int unsigned addr_bits = 16,
   parameter int unsigned data_bits = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 p0_req,
   input  logic                 p0_write,
   input  logic [addr_bits-1:0] p0_address,
   input  logic [data_bits-1:0] p0_data_in,
   output logic                 p0_ack,
   output logic [data_bits-1:0] p0_data_out,
   input  logic                 p1_req,
   input  logic                 p1_write,
   input  logic [addr_bits-1:0] p1_address,
   input  logic [data_bits-1:0] p1_data_in,
   output logic                 p1_ack,
   output logic [data_bits-1:0] p1_data_out,
   output logic                 ram_write_enable,
   output logic [addr_bits-1:0] ram_address,
   output logic [data_bits-1:0] ram_data_in,
   input  logic [data_bits-1:0] ram_data_out
);

   typedef enum logic [1:0] {StIdle, StAccess, StAck} state_t;

   state_t               r_state,     w_state_nxt;
   logic                 r_ram_we,    w_ram_we_nxt;
   logic [addr_bits-1:0] r_ram_addr,  w_ram_addr_nxt;
   logic [data_bits-1:0] r_ram_din,   w_ram_din_nxt;
   logic                 r_p0_ack,    w_p0_ack_nxt;
   logic                 r_p1_ack,    w_p1_ack_nxt;
   logic [data_bits-1:0] r_p0_dout,   w_p0_dout_nxt;
   logic [data_bits-1:0] r_p1_dout,   w_p1_dout_nxt;
   logic                 r_winner,    w_winner_nxt;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
   logic                 r_last_grant, w_last_grant_nxt;
`endif

   logic w_any_req;
   logic w_grant;   // index of the port served at this arbitration edge

   // Arbitration: choose which requesting port wins this edge
   always_comb begin
      w_any_req = p0_req | p1_req;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
      // On conflict the port not granted last wins; otherwise the lone requester
      if (p0_req && p1_req) begin
         w_grant = ~r_last_grant;
      end else begin
         w_grant = p1_req;
      end
`else
      // Port 1 is only served when port 0 is not requesting
      w_grant = ~p0_req;
`endif
   end

   // Next-state and registered-output logic for the IDLE/ACCESS/ACK sequence
   always_comb begin
      w_state_nxt    = r_state;
      w_ram_we_nxt   = r_ram_we;
      w_ram_addr_nxt = r_ram_addr;
      w_ram_din_nxt  = r_ram_din;
      w_p0_ack_nxt   = 1'b0;
      w_p1_ack_nxt   = 1'b0;
      w_p0_dout_nxt  = r_p0_dout;
      w_p1_dout_nxt  = r_p1_dout;
      w_winner_nxt   = r_winner;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
      w_last_grant_nxt = r_last_grant;
`endif
      unique case (r_state)
         StIdle, StAck: begin
            w_ram_we_nxt = 1'b0;
            if (w_any_req) begin
               w_state_nxt    = StAccess;
               w_winner_nxt   = w_grant;
               w_ram_addr_nxt = w_grant ? p1_address : p0_address;
               w_ram_din_nxt  = w_grant ? p1_data_in : p0_data_in;
               w_ram_we_nxt   = w_grant ? p1_write   : p0_write;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
               w_last_grant_nxt = w_grant;
`endif
            end else begin
               w_state_nxt = StIdle;
            end
         end
         StAccess: begin
            // RAM has acted on the negedge; its output (read data or echoed write
            // data) is returned to the winner only
            w_state_nxt  = StAck;
            w_ram_we_nxt = 1'b0;
            if (r_winner) begin
               w_p1_ack_nxt  = 1'b1;
               w_p1_dout_nxt = ram_data_out;
            end else begin
               w_p0_ack_nxt  = 1'b1;
               w_p0_dout_nxt = ram_data_out;
            end
         end
         default: begin
            w_state_nxt  = StIdle;
            w_ram_we_nxt = 1'b0;
         end
      endcase
   end

   // State and output registers; async reset also kills an in-flight RAM write
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= StIdle;
         r_ram_we   <= 1'b0;
         r_ram_addr <= '0;
         r_ram_din  <= '0;
         r_p0_ack   <= 1'b0;
         r_p1_ack   <= 1'b0;
         r_p0_dout  <= '0;
         r_p1_dout  <= '0;
         r_winner   <= 1'b0;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
         r_last_grant <= 1'b1;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_ram_we   <= w_ram_we_nxt;
         r_ram_addr <= w_ram_addr_nxt;
         r_ram_din  <= w_ram_din_nxt;
         r_p0_ack   <= w_p0_ack_nxt;
         r_p1_ack   <= w_p1_ack_nxt;
         r_p0_dout  <= w_p0_dout_nxt;
         r_p1_dout  <= w_p1_dout_nxt;
         r_winner   <= w_winner_nxt;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
         r_last_grant <= w_last_grant_nxt;
`endif
      end
   end

   assign ram_write_enable = r_ram_we;
   assign ram_address      = r_ram_addr;
   assign ram_data_in      = r_ram_din;
   assign p0_ack           = r_p0_ack;
   assign p1_ack           = r_p1_ack;
   assign p0_data_out      = r_p0_dout;
   assign p1_data_out      = r_p1_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios plus a randomized two-port run
// checked against a transaction-level model of RAM contents and grant order.
module tb_ram_arbiter;

   localparam int AW = 16;
   localparam int DW = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          p0_req, p1_req, p0_write, p1_write;
   logic [AW-1:0] p0_address, p1_address;
   logic [DW-1:0] p0_data_in, p1_data_in, p0_data_out, p1_data_out;
   logic          p0_ack, p1_ack;
   logic          ram_write_enable;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data_in;
   logic [DW-1:0] ram_data_out = '0;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Bench-side RAM: acts on negedge, echoes written data; preload port for setup
   logic [DW-1:0] ram_mem [0:65535];
   logic          pre_we = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [DW-1:0] pre_data = '0;

   always @(negedge clock) begin
      if (pre_we) begin
         ram_mem[pre_addr] <= pre_data;
      end else if (ram_write_enable) begin
         ram_mem[ram_address] <= ram_data_in;
         ram_data_out         <= ram_data_in;
      end else begin
         ram_data_out <= ram_mem[ram_address];
      end
   end

   ram_arbiter #(.addr_bits(AW), .data_bits(DW)) dut (
      .clock            (clock),
      .reset            (reset),
      .p0_req           (p0_req),
      .p0_write         (p0_write),
      .p0_address       (p0_address),
      .p0_data_in       (p0_data_in),
      .p0_ack           (p0_ack),
      .p0_data_out      (p0_data_out),
      .p1_req           (p1_req),
      .p1_write         (p1_write),
      .p1_address       (p1_address),
      .p1_data_in       (p1_data_in),
      .p1_ack           (p1_ack),
      .p1_data_out      (p1_data_out),
      .ram_write_enable (ram_write_enable),
      .ram_address      (ram_address),
      .ram_data_in      (ram_data_in),
      .ram_data_out     (ram_data_out)
   );

   initial forever #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: observed no end of test, required finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      @(negedge clock);
      #1;
      pre_we = 1'b0;
   endtask

   task automatic drive(input int p, input logic rq, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (p == 0) begin
         p0_req = rq; p0_write = wr; p0_address = a; p0_data_in = d;
      end else begin
         p1_req = rq; p1_write = wr; p1_address = a; p1_data_in = d;
      end
   endtask

   task automatic set_req(input int p, input logic rq);
      if (p == 0) p0_req = rq;
      else        p1_req = rq;
   endtask

   function automatic logic get_ack(input int p);
      return (p == 0) ? p0_ack : p1_ack;
   endfunction

   function automatic logic [DW-1:0] get_dout(input int p);
      return (p == 0) ? p0_data_out : p1_data_out;
   endfunction

   task automatic start_reset();
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
      tick();
   endtask

   task automatic end_reset();
      reset = 1'b0;
      tick();
   endtask

   // One isolated transaction: req held until ack, dropped during the ACK cycle
   task automatic txn(input int p, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output logic [DW-1:0] q,
                      output int lat, output int we_cyc, output int other_ack);
      drive(p, 1'b1, wr, a, d);
      lat = 0; we_cyc = 0; other_ack = 0;
      do begin
         tick();
         lat++;
         if (ram_write_enable) we_cyc++;
         if (get_ack(1 - p)) other_ack++;
      end while (!get_ack(p) && lat < 20);
      q = get_dout(p);
      set_req(p, 1'b0);
      tick();
      if (ram_write_enable) we_cyc++;
      if (get_ack(1 - p)) other_ack++;
   endtask

   logic [DW-1:0] q;
   int            lat, wec, oa;
   logic [DW-1:0] model_mem [16];

   initial begin
      // ---------------- reset and idle ----------------
      start_reset();
      preload(16'h0010, 8'h5A);
      preload(16'h0001, 8'h11);
      preload(16'h0002, 8'h22);
      preload(16'h0003, 8'h33);
      preload(16'h0040, 8'h77);
      end_reset();
      for (int i = 0; i < 10; i++) begin
         check("idle_outputs",
               {p0_ack, p1_ack, ram_write_enable, ram_address, ram_data_in,
                p0_data_out, p1_data_out}, 64'h0);
         tick();
      end

      // ---------------- p0 read of preloaded word ----------------
      txn(0, 1'b0, 16'h0010, 8'h00, q, lat, wec, oa);
      check("p0_read_latency", lat, 2);
      check("p0_read_data", q, 8'h5A);
      check("p0_read_p1_ack", oa, 0);
      check("p0_dout_held", p0_data_out, 8'h5A);

      // ---------------- p1 write then p0 read back ----------------
      txn(1, 1'b1, 16'h0200, 8'hC3, q, lat, wec, oa);
      check("p1_write_latency", lat, 2);
      check("p1_write_echo", q, 8'hC3);
      check("p1_write_we_cycles", wec, 1);
      check("p1_write_ram", ram_mem[16'h0200], 8'hC3);
      check("p0_dout_untouched", p0_data_out, 8'h5A);
      txn(0, 1'b0, 16'h0200, 8'h00, q, lat, wec, oa);
      check("p0_readback", q, 8'hC3);
      check("p0_read_we_cycles", wec, 0);
      check("p1_dout_untouched", p1_data_out, 8'hC3);

      // ---------------- back-to-back reads on p0 ----------------
      begin
         int k;
         int ack_cyc[3];
         int t0;
         logic [DW-1:0] exp_b2b[3];
         exp_b2b[0] = 8'h11; exp_b2b[1] = 8'h22; exp_b2b[2] = 8'h33;
         k = 0;
         t0 = cyc;
         drive(0, 1'b1, 1'b0, 16'h0001, 8'h00);
         for (int i = 0; i < 20 && k < 3; i++) begin
            tick();
            if (p0_ack) begin
               check("b2b_data", p0_data_out, exp_b2b[k]);
               ack_cyc[k] = cyc;
               k++;
               if (k < 3) drive(0, 1'b1, 1'b0, 16'(k + 1), 8'h00);
               else       set_req(0, 1'b0);
            end
         end
         check("b2b_ack_count", k, 3);
         if (k == 3) begin
            check("b2b_first_latency", ack_cyc[0] - t0, 2);
            check("b2b_spacing_01", ack_cyc[1] - ack_cyc[0], 2);
            check("b2b_spacing_12", ack_cyc[2] - ack_cyc[1], 2);
         end
         tick();
      end

      // ---------------- reset during ACCESS of a p1 write ----------------
      begin
         int stray;
         drive(1, 1'b1, 1'b1, 16'h0040, 8'hFF);
         tick();
         check("abort_we_before_reset", ram_write_enable, 1'b1);
         check("abort_addr", ram_address, 16'h0040);
         #1;
         reset = 1'b1;
         #1;
         check("abort_we_cleared", ram_write_enable, 1'b0);
         check("abort_acks_cleared", {p0_ack, p1_ack}, 2'b00);
         set_req(1, 1'b0);
         stray = 0;
         for (int i = 0; i < 3; i++) begin
            tick();
            if (p0_ack || p1_ack) stray++;
         end
         reset = 1'b0;
         for (int i = 0; i < 4; i++) begin
            tick();
            if (p0_ack || p1_ack) stray++;
         end
         check("abort_no_ack", stray, 0);
         check("abort_ram_unchanged", ram_mem[16'h0040], 8'h77);
         check("abort_ram_addr_reset", ram_address, 16'h0000);
         txn(0, 1'b0, 16'h0040, 8'h00, q, lat, wec, oa);
         check("abort_then_idle_latency", lat, 2);
         check("abort_then_read", q, 8'h77);
      end

      // ---------------- contention: 4 reads per port ----------------
      begin
         int i0, i1, n0, n1, last, w;
         int order[$];
         int exp_order[$];
         start_reset();
         for (int i = 0; i < 4; i++) begin
            preload(16'(16'h0100 + i), 8'(8'hA0 + i));
            preload(16'(16'h0180 + i), 8'(8'hB0 + i));
         end
         end_reset();
         i0 = 0; i1 = 0;
         drive(0, 1'b1, 1'b0, 16'h0100, 8'h00);
         drive(1, 1'b1, 1'b0, 16'h0180, 8'h00);
         for (int c = 0; c < 60 && (i0 < 4 || i1 < 4); c++) begin
            tick();
            if (p0_ack && p1_ack) check("cont_ack_onehot", {p0_ack, p1_ack}, 2'b01);
            if (p0_ack) begin
               order.push_back(0);
               check("cont_p0_data", p0_data_out, 8'(8'hA0 + i0));
               i0++;
               if (i0 < 4) drive(0, 1'b1, 1'b0, 16'(16'h0100 + i0), 8'h00);
               else        set_req(0, 1'b0);
            end
            if (p1_ack) begin
               order.push_back(1);
               check("cont_p1_data", p1_data_out, 8'(8'hB0 + i1));
               i1++;
               if (i1 < 4) drive(1, 1'b1, 1'b0, 16'(16'h0180 + i1), 8'h00);
               else        set_req(1, 1'b0);
            end
         end
         // Expected grant sequence from the arbitration rule alone
         n0 = 4; n1 = 4; last = 1;
         while (n0 + n1 > 0) begin
            if (n0 > 0 && n1 > 0) begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
               w = 1 - last;
`else
               w = 0;
`endif
            end else begin
               w = (n0 > 0) ? 0 : 1;
            end
            last = w;
            exp_order.push_back(w);
            if (w == 0) n0--;
            else        n1--;
         end
         check("cont_grant_count", order.size(), 8);
         for (int i = 0; i < 8 && i < order.size(); i++) begin
            check($sformatf("cont_grant_%0d", i), order[i], exp_order[i]);
         end
         set_req(0, 1'b0);
         set_req(1, 1'b0);
         tick();
      end

      // ---------------- randomized two-port traffic ----------------
      begin
         logic          act[2];
         logic          wr[2];
         logic [3:0]    off[2];
         logic [DW-1:0] dt[2];
         logic [DW-1:0] exp_q[2];
         int            waitc[2];
         int            max_wait, last_ack, done;
         logic          a[2];
         logic [DW-1:0] e;
         start_reset();
         for (int i = 0; i < 16; i++) begin
            model_mem[i] = 8'($urandom);
            preload(16'(16'h0300 + i), model_mem[i]);
         end
         end_reset();
         for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0; exp_q[p] = '0; waitc[p] = 0;
            wr[p] = 1'b0; off[p] = '0; dt[p] = '0;
         end
         max_wait = 0; last_ack = -10; done = 0;
         for (int c = 0; c < 600; c++) begin
            tick();
            a[0] = p0_ack;
            a[1] = p1_ack;
            if (a[0] && a[1]) check("rnd_ack_onehot", {a[0], a[1]}, 2'b01);
            if (a[0] || a[1]) begin
               check("rnd_ack_spacing", (cyc - last_ack) >= 2, 1'b1);
               last_ack = cyc;
            end
            for (int p = 0; p < 2; p++) begin
               if (a[p]) begin
                  check("rnd_ack_without_req", act[p], 1'b1);
                  e = wr[p] ? dt[p] : model_mem[off[p]];
                  if (wr[p]) model_mem[off[p]] = dt[p];
                  exp_q[p] = e;
                  check($sformatf("rnd_p%0d_data", p), get_dout(p), e);
                  if (waitc[p] > max_wait) max_wait = waitc[p];
                  if (c < 400 && $urandom_range(1, 0) == 1) begin
                     wr[p] = 1'($urandom); off[p] = 4'($urandom); dt[p] = 8'($urandom);
                     drive(p, 1'b1, wr[p], 16'(16'h0300 + off[p]), dt[p]);
                     waitc[p] = 0;
                  end else begin
                     set_req(p, 1'b0);
                     act[p] = 1'b0;
                  end
               end else begin
                  check($sformatf("rnd_p%0d_dout_hold", p), get_dout(p), exp_q[p]);
                  if (act[p]) begin
                     waitc[p]++;
                  end else if (c < 400 && $urandom_range(2, 0) == 0) begin
                     wr[p] = 1'($urandom); off[p] = 4'($urandom); dt[p] = 8'($urandom);
                     drive(p, 1'b1, wr[p], 16'(16'h0300 + off[p]), dt[p]);
                     act[p] = 1'b1;
                     waitc[p] = 0;
                  end
               end
            end
            if (a[0] || a[1]) done++;
            if (c >= 400 && !act[0] && !act[1]) break;
         end
         check("rnd_drained", {act[0], act[1]}, 2'b00);
         check("rnd_max_wait_bound", max_wait < 100, 1'b1);
         check("rnd_some_traffic", done > 20, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port `ram` between two requesters: port 0 is the CPU core and port 1 is the host loader/debug port. It serializes requests with a fixed handshake and drives the RAM's write enable, address and data lines from registers. It captures the RAM read data and returns it to the winning port with a one-cycle `ack` pulse. The block sits between the core/loader and the `ram` instance; nothing else drives the RAM.

## Interface
Parameters:
- `addr_bits`, 16, RAM address width
- `data_bits`, 8, RAM data width

Ports. Clock and reset are one clock `clock`, with reset `reset` asynchronous and active-high.
- `clock`  in  1  system clock; arbiter acts on posedge, RAM on negedge
- `reset`  in  1  asynchronous, active-high
- `p0_req`, `p1_req`  in  1  request valid, held until `ack`
- `p0_write`, `p1_write`  in  1  1 = write, 0 = read
- `p0_address`, `p1_address`  in  `addr_bits`  access address
- `p0_data_in`, `p1_data_in`  in  `data_bits`  write data
- `p0_ack`, `p1_ack`  out  1  one-cycle completion pulse
- `p0_data_out`, `p1_data_out`  out  `data_bits`  read data, valid while `ack` is high and held afterwards
- `ram_write_enable`  out  1  to RAM `write_enable`
- `ram_address`  out  `addr_bits`  to RAM `address`
- `ram_data_in`  out  `data_bits`  to RAM `data_in`
- `ram_data_out`  in  `data_bits`  from RAM `data_out`

## Operation
- States: IDLE, ACCESS, ACK. Reset enters IDLE.
- IDLE: if any `req` is sampled high, arbitrate and go to ACCESS; otherwise stay in IDLE.
- On entry to ACCESS:
  - register the winner's address and data into `ram_address` / `ram_data_in`;
  - set `ram_write_enable` to the winner's `write`;
  - record the winner index.
- ACCESS lasts exactly one cycle. The RAM performs the access at the negedge inside this cycle. Then go to ACK unconditionally.
- On entry to ACK:
  - capture `ram_data_out` into the winner's `data_out`;
  - pulse the winner's `ack` for one cycle;
  - force `ram_write_enable` to 0.
- A write returns the written data on `data_out`, because the RAM echoes `data_in`.
- ACK arbitrates exactly as IDLE does: go to ACCESS if any `req` is high, else go to IDLE.
- The `req` value sampled at the edge that ends a port's ACK cycle counts as a new transaction. A requester with no further work deasserts `req` during its ACK cycle.
- The non-winning port's `ack` stays 0 and its `data_out` is unchanged.
- Requesters must hold `write`, `address` and `data_in` stable from `req` rise until `ack`. The arbiter samples them only at the ACCESS entry edge.
- `ram_address` and `ram_data_in` hold their last value outside ACCESS. `ram_write_enable` is 1 only during ACCESS of a write.

## Timing
- Reset values: state IDLE; `p0_ack`, `p1_ack`, `ram_write_enable` = 0; `ram_address`, `ram_data_in`, `p0_data_out`, `p1_data_out` = 0; last-grant register = 1.
- Latency: `req` high at posedge k (state IDLE or ACK) gives ACCESS in cycle k..k+1 and `ack` in cycle k+1..k+2.
- Throughput: one access per 2 cycles. Back-to-back ACCESS/ACK alternation holds with no IDLE gap.
- Simultaneous requests: only one port is granted per arbitration; the other waits with its `req` held.
- Reset mid-operation:
  - Asserting `reset` immediately clears `ram_write_enable` and both `ack` outputs.
  - A write in ACCESS whose negedge has not yet occurred must not reach the RAM.
  - No `ack` is issued for the aborted transaction.
- A `req` dropped before its `ack` is a protocol violation and its behaviour is undefined. The bench must not generate it.

## Configuration
- `RAM_ARBITER_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - The port not granted last wins on conflict.
  - The last-grant register updates on every grant. Its reset value of 1 makes port 0 win first.
- Not defined: fixed priority, port 0 always wins on conflict. Port 1 is served only when `p0_req` is low at an arbitration edge. The last-grant register is not implemented.

## Test plan
- RAM preloaded with 0x5A at 0x0010; `p0` read of 0x0010 -> `p0_ack` two cycles after the `req` edge, `p0_data_out` = 0x5A, `p1_ack` stays 0.
- `p1` write of 0xC3 to 0x0200, then `p0` read of 0x0200 -> `p1_data_out` = 0xC3 on the write ack; the read returns 0xC3; `ram_write_enable` high for exactly one cycle.
- Both ports request continuously with 4 reads each:
  - with the macro, grants alternate 0,1,0,1…;
  - without it, all 4 port-0 reads complete before any port-1 read.
- `p0` keeps `req` high across 3 back-to-back reads of 0x0001 to 0x0003 -> the pattern ACCESS, ACK repeats with no IDLE cycle and 3 `ack` pulses at a 2-cycle spacing.
- `reset` asserted during ACCESS of a `p1` write of 0xFF to 0x0040, before the negedge -> `ram_write_enable` drops at once, RAM[0x0040] is unchanged, no `ack` is issued, and the state is IDLE.
- No `req` for 10 cycles after reset -> the state stays IDLE and all outputs hold their reset values.
